fp_regfile_mp: RTL and testbench

Parametrised multi-port floating-point register file with double-precision pair access, write-to-read bypass and a per-register pending-write scoreboard. Sits in the decode/writeback boundary of the FP pipeline: decode reads operands and marks destinations busy at issue, writeback retires results and clears busy. Replaces the fixed 32×32, two-read, uninitialised-storage FP register bank.

---
 rtl/fp_rf_pkg.sv | 23 ++
 rtl/fp_regfile_mp_if.sv | 39 +++
 rtl/fp_rf_scoreboard.sv | 62 ++++++
 rtl/fp_regfile_mp.sv | 103 ++++++++++
 tb/tb_fp_regfile_mp.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_rf_pkg.sv
// Shared constants and address helpers for the FP register file slice.
package fp_rf_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_NUM_RD   = 2;

   // Address width needed to index a register bank of the given depth.
   function automatic int unsigned addrW(input int unsigned numRegs);
      return $clog2(numRegs);
   endfunction

   // Even member of the pair that contains address a.
   function automatic int unsigned pairEven(input int unsigned a);
      return a & 32'hFFFF_FFFE;
   endfunction

   // Odd member of the pair that contains address a.
   function automatic int unsigned pairOdd(input int unsigned a);
      return a | 32'd1;
   endfunction

endpackage

// File: rtl/fp_regfile_mp_if.sv
// Decode/writeback bus of the FP register file: read ports, writeback, issue, scoreboard.
interface fp_regfile_mp_if
   import fp_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD
) ();

   localparam int unsigned ADDR_W = addrW(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD-1:0]          rd_dbl;
   logic [NUM_RD*2*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]          rd_busy;

   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic                       wr_dbl;
   logic [2*DATA_W-1:0]        wr_data;

   logic                       iss_en;
   logic [ADDR_W-1:0]          iss_addr;
   logic                       iss_dbl;

   logic [NUM_REGS-1:0]        busy_vec;
   logic                       iss_waw;

   modport master (
      output rd_addr, rd_dbl, wr_en, wr_addr, wr_dbl, wr_data, iss_en, iss_addr, iss_dbl,
      input  rd_data, rd_busy, busy_vec, iss_waw
   );

   modport slave (
      input  rd_addr, rd_dbl, wr_en, wr_addr, wr_dbl, wr_data, iss_en, iss_addr, iss_dbl,
      output rd_data, rd_busy, busy_vec, iss_waw
   );

endinterface

// File: rtl/fp_rf_scoreboard.sv
// Pending-write scoreboard: issue sets, writeback clears, set wins on the same register.
module fp_rf_scoreboard
   import fp_rf_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wrEn,
   input  logic [addrW(NUM_REGS)-1:0]       wrAddr,
   input  logic                             wrDbl,
   input  logic                             issEn,
   input  logic [addrW(NUM_REGS)-1:0]       issAddr,
   input  logic                             issDbl,
   output logic [NUM_REGS-1:0]              busyVec,
   output logic [NUM_REGS-1:0]              busyNext_c,
   output logic                             issWaw
);

   localparam int unsigned ADDR_W = addrW(NUM_REGS);

   logic [NUM_REGS-1:0] wrMask_c;
   logic [NUM_REGS-1:0] issMask_c;
   logic                wawNext_c;

   // One-hot (or pair) mask of the registers touched by a strobe.
   function automatic logic [NUM_REGS-1:0] regMask(input logic en,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic dbl);
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (en) begin
         if (dbl) begin
            m[ADDR_W'(pairEven(32'(a)))] = 1'b1;
            m[ADDR_W'(pairOdd(32'(a)))]  = 1'b1;
         end else begin
            m[a] = 1'b1;
         end
      end
      return m;
   endfunction

   // Next busy state and hazard detection; clear first so a same-register issue wins.
   always_comb begin
      wrMask_c   = regMask(wrEn, wrAddr, wrDbl);
      issMask_c  = regMask(issEn, issAddr, issDbl);
      busyNext_c = (busyVec & ~wrMask_c) | issMask_c;
      wawNext_c  = |(issMask_c & busyVec & ~wrMask_c);
   end

   // Scoreboard and one-cycle WAW pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyVec <= '0;
         issWaw  <= 1'b0;
      end else begin
         busyVec <= busyNext_c;
         issWaw  <= wawNext_c;
      end
   end

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with pair access, write-to-read bypass and pending-write scoreboard.
module fp_regfile_mp
   import fp_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_regfile_mp_if.slave  rf
);

   localparam int unsigned ADDR_W = addrW(NUM_REGS);
   localparam int unsigned PORT_W = 2 * DATA_W;

   logic [DATA_W-1:0]        regFile   [NUM_REGS];
   logic [DATA_W-1:0]        regNext_c [NUM_REGS];
   logic [NUM_REGS-1:0]      busyVec;
   logic [NUM_REGS-1:0]      busyNext_c;
   logic                     issWaw;
   logic [NUM_RD*PORT_W-1:0] rdDataNext_c;
   logic [NUM_RD-1:0]        rdBusyNext_c;
   logic [ADDR_W-1:0]        wrEven_c;
   logic [ADDR_W-1:0]        wrOdd_c;

   assign wrEven_c = ADDR_W'(pairEven(32'(rf.wr_addr)));
   assign wrOdd_c  = ADDR_W'(pairOdd(32'(rf.wr_addr)));

   // Post-write view of the bank; feeds both storage and the read bypass.
   always_comb begin
      regNext_c = regFile;
      if (rf.wr_en) begin
         if (rf.wr_dbl) begin
            regNext_c[wrEven_c] = rf.wr_data[DATA_W-1:0];
            regNext_c[wrOdd_c]  = rf.wr_data[PORT_W-1:DATA_W];
         end else begin
            regNext_c[rf.wr_addr] = rf.wr_data[DATA_W-1:0];
         end
      end
   end

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regFile[i] <= '0;
         end
      end else begin
         regFile <= regNext_c;
      end
   end

   fp_rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrEn       (rf.wr_en),
      .wrAddr     (rf.wr_addr),
      .wrDbl      (rf.wr_dbl),
      .issEn      (rf.iss_en),
      .issAddr    (rf.iss_addr),
      .issDbl     (rf.iss_dbl),
      .busyVec    (busyVec),
      .busyNext_c (busyNext_c),
      .issWaw     (issWaw)
   );

   assign rf.busy_vec = busyVec;
   assign rf.iss_waw  = issWaw;

   // Per-port read mux over the post-write bank and post-edge busy bits.
   for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] evenA;
      logic [ADDR_W-1:0] oddA;

      assign addr  = rf.rd_addr[p*ADDR_W +: ADDR_W];
      assign evenA = ADDR_W'(pairEven(32'(addr)));
      assign oddA  = ADDR_W'(pairOdd(32'(addr)));

      assign rdDataNext_c[p*PORT_W +: PORT_W] = rf.rd_dbl[p]
         ? {regNext_c[oddA], regNext_c[evenA]}
         : {{DATA_W{1'b0}}, regNext_c[addr]};

      assign rdBusyNext_c[p] = rf.rd_dbl[p]
         ? (busyNext_c[oddA] | busyNext_c[evenA])
         : busyNext_c[addr];
   end

   // Registered read data and busy flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf.rd_data <= '0;
         rf.rd_busy <= '0;
      end else begin
         rf.rd_data <= rdDataNext_c;
         rf.rd_busy <= rdBusyNext_c;
      end
   end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Self-checking bench for fp_regfile_mp: directed plan steps, random traffic, async reset.
module tb_fp_regfile_mp;

   localparam int unsigned DW  = 32;
   localparam int unsigned NR  = 32;
   localparam int unsigned NRD = 2;
   localparam int unsigned AW  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp_regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

   fp_regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [DW-1:0] mReg  [NR];
   logic          mBusy [NR];
   logic          mWaw;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < int'(NR); i++) begin
         mReg[i]  = '0;
         mBusy[i] = 1'b0;
      end
      mWaw = 1'b0;
   endtask

   task automatic clearIn();
      bus.rd_addr  = '0;
      bus.rd_dbl   = '0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_dbl   = 1'b0;
      bus.wr_data  = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
      bus.iss_dbl  = 1'b0;
   endtask

   task automatic randIn();
      bus.rd_addr  = (NRD*AW)'($urandom);
      bus.rd_dbl   = NRD'($urandom);
      bus.wr_en    = 1'($urandom);
      bus.wr_addr  = AW'($urandom);
      bus.wr_dbl   = 1'($urandom);
      bus.wr_data  = {$urandom, $urandom};
      bus.iss_en   = 1'($urandom);
      bus.iss_addr = AW'($urandom);
      bus.iss_dbl  = 1'($urandom);
   endtask

   // Compare every registered output against the model.
   task automatic checkAll(input string tag);
      logic [NR-1:0] bv;
      for (int i = 0; i < int'(NR); i++) bv[i] = mBusy[i];
      check({tag, ".busy_vec"}, 128'(bus.busy_vec), 128'(bv));
      check({tag, ".iss_waw"}, 128'(bus.iss_waw), 128'(mWaw));
      for (int p = 0; p < int'(NRD); p++) begin
         int a;
         int e;
         logic [63:0] expD;
         logic        expB;
         a = int'(bus.rd_addr[p*AW +: AW]);
         e = a & ~1;
         if (bus.rd_dbl[p]) begin
            expD = {mReg[e+1], mReg[e]};
            expB = mBusy[e] | mBusy[e+1];
         end else begin
            expD = {32'h0, mReg[a]};
            expB = mBusy[a];
         end
         check($sformatf("%s.rd_data%0d", tag, p), 128'(bus.rd_data[p*64 +: 64]), 128'(expD));
         check($sformatf("%s.rd_busy%0d", tag, p), 128'(bus.rd_busy[p]), 128'(expB));
      end
   endtask

   // Apply current inputs for one clock, advance the model, check outputs.
   task automatic cycle(input string tag);
      logic          wrEn, wrDbl, issEn, issDbl;
      int            wA, iA;
      logic [63:0]   wd;
      logic          wrHit  [NR];
      logic          issHit [NR];
      wrEn  = bus.wr_en;   wrDbl  = bus.wr_dbl;  wA = int'(bus.wr_addr);  wd = bus.wr_data;
      issEn = bus.iss_en;  issDbl = bus.iss_dbl; iA = int'(bus.iss_addr);
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NR); i++) begin
         wrHit[i]  = 1'b0;
         issHit[i] = 1'b0;
      end
      if (wrEn) begin
         if (wrDbl) begin
            mReg[wA & ~1]       = wd[31:0];
            mReg[(wA & ~1) + 1] = wd[63:32];
            wrHit[wA & ~1]       = 1'b1;
            wrHit[(wA & ~1) + 1] = 1'b1;
         end else begin
            mReg[wA]  = wd[31:0];
            wrHit[wA] = 1'b1;
         end
      end
      if (issEn) begin
         if (issDbl) begin
            issHit[iA & ~1]       = 1'b1;
            issHit[(iA & ~1) + 1] = 1'b1;
         end else begin
            issHit[iA] = 1'b1;
         end
      end
      mWaw = 1'b0;
      for (int i = 0; i < int'(NR); i++)
         if (issHit[i] && mBusy[i] && !wrHit[i]) mWaw = 1'b1;
      for (int i = 0; i < int'(NR); i++) begin
         if (wrHit[i])  mBusy[i] = 1'b0;
         if (issHit[i]) mBusy[i] = 1'b1;
      end
      checkAll(tag);
   endtask

   task automatic checkZero(input string tag);
      check({tag, ".rd_data"}, 128'(bus.rd_data), 128'h0);
      check({tag, ".rd_busy"}, 128'(bus.rd_busy), 128'h0);
      check({tag, ".busy_vec"}, 128'(bus.busy_vec), 128'h0);
      check({tag, ".iss_waw"}, 128'(bus.iss_waw), 128'h0);
   endtask

   initial begin
      clearIn();
      modelReset();
      #12;
      checkZero("por");
      rst_n = 1'b1;

      // Idle read of reg 0
      cycle("idle");

      // Single write then read
      bus.wr_en = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 64'h0000_0000_4049_0FDB;
      cycle("wr5");
      clearIn();
      bus.rd_addr[0 +: AW] = AW'(5);
      cycle("rd5");
      check("rd5_const", 128'(bus.rd_data[63:0]), 128'h0000_0000_4049_0FDB);

      // Pair write with odd address, pair read with even address
      bus.rd_addr = '0;
      bus.wr_en = 1'b1; bus.wr_dbl = 1'b1; bus.wr_addr = AW'(3);
      bus.wr_data = 64'h400921FB_54442D18;
      cycle("wrpair");
      clearIn();
      bus.rd_addr[AW +: AW] = AW'(2); bus.rd_dbl[1] = 1'b1;
      cycle("rdpair");
      check("rdpair_const", 128'(bus.rd_data[127:64]), 128'h400921FB_54442D18);

      // Same-cycle bypass on both ports
      clearIn();
      bus.wr_en = 1'b1; bus.wr_addr = AW'(7); bus.wr_data = 64'h0000_0000_C070_0000;
      bus.rd_addr = {AW'(7), AW'(7)};
      cycle("bypass");
      check("bypass_p0", 128'(bus.rd_data[63:0]), 128'h0000_0000_C070_0000);
      check("bypass_p1", 128'(bus.rd_data[127:64]), 128'h0000_0000_C070_0000);

      // Pair read overlapping a single write: new half + old half
      clearIn();
      bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = 64'hFFFF_FFFF_1111_2222;
      bus.rd_addr[0 +: AW] = AW'(3); bus.rd_dbl[0] = 1'b1;
      cycle("bypass_half");
      check("bypass_half_const", 128'(bus.rd_data[63:0]), 128'h400921FB_1111_2222);

      // Scoreboard set, clear, set-wins
      clearIn();
      bus.iss_en = 1'b1; bus.iss_addr = AW'(9); bus.rd_addr[0 +: AW] = AW'(9);
      cycle("iss9");
      check("iss9_bv", 128'(bus.busy_vec[9]), 128'h1);
      check("iss9_rdbusy", 128'(bus.rd_busy[0]), 128'h1);
      bus.iss_en = 1'b0; bus.wr_en = 1'b1; bus.wr_addr = AW'(9);
      cycle("wr9");
      check("wr9_bv", 128'(bus.busy_vec[9]), 128'h0);
      bus.iss_en = 1'b1; bus.iss_addr = AW'(9);
      cycle("isswr9");
      check("isswr9_bv", 128'(bus.busy_vec[9]), 128'h1);
      clearIn();
      bus.wr_en = 1'b1; bus.wr_addr = AW'(9);
      cycle("clr9");

      // WAW pulse for exactly one cycle
      clearIn();
      bus.iss_en = 1'b1; bus.iss_addr = AW'(4);
      cycle("waw_a");
      cycle("waw_b");
      check("waw_pulse", 128'(bus.iss_waw), 128'h1);
      clearIn();
      cycle("waw_c");
      check("waw_drop", 128'(bus.iss_waw), 128'h0);

      // Second issue with simultaneous writeback: no pulse
      bus.wr_en = 1'b1; bus.wr_addr = AW'(4);
      cycle("waw_clr");
      clearIn();
      bus.iss_en = 1'b1; bus.iss_addr = AW'(4);
      cycle("waw_d");
      bus.wr_en = 1'b1; bus.wr_addr = AW'(4);
      cycle("waw_e");
      check("waw_nopulse", 128'(bus.iss_waw), 128'h0);
      check("waw_e_bv", 128'(bus.busy_vec[4]), 128'h1);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         randIn();
         cycle("rand");
      end

      // Asynchronous reset mid-cycle
      clearIn();
      #3;
      rst_n = 1'b0;
      #1;
      checkZero("async_rst");
      modelReset();
      #3;
      rst_n = 1'b1;

      // Every register reads back zero after reset
      for (int r = 0; r < int'(NR); r += 2) begin
         bus.rd_addr = {AW'(r + 1), AW'(r)};
         bus.rd_dbl  = '0;
         cycle("post_rst");
      end

      for (int n = 0; n < 200; n++) begin
         randIn();
         cycle("rand2");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
